// File: rtl/aes_pkg.sv
// Shared AES-256 inverse-cipher definitions: round count, FSM encoding,
// inverse S-box table and the GF(2^8) column/row helpers.
package aes_pkg;

    localparam int NR = 14;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Entry [i] is InvSbox(i); row n of the literal covers inputs 16n..16n+15.
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant as a sum of the x2/x4/x8 xtime chain.
    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] m);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (m[0] ? b : 8'h00) ^ (m[1] ? x2 : 8'h00) ^
               (m[2] ? x4 : 8'h00) ^ (m[3] ? x8 : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        {a0, a1, a2, a3} = col;
        return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
                gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
                gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
                gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
    endfunction

    // Byte 4c+r is row r, column c; row r rotates right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c-row+4)%4)+row) -: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Single-byte inverse S-box lookup.
module aes_inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] addr,
    output logic [7:0] data
);

    assign data = INV_SBOX[addr];

endmodule

// File: rtl/aes_dec_ctrl.sv
// Iterative AES-256 inverse cipher: one round per clock, round keys fetched
// by index from an external key store, plaintext returned over valid/ready.
module aes_dec_ctrl
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    state_t       state_reg, state_next;
    logic [3:0]   round_reg, round_next;
    logic [127:0] data_reg, data_next;

    logic [127:0] shifted;
    logic [127:0] subbed;
    logic [127:0] added;
    logic [127:0] mixed;

    assign shifted = inv_shift_rows(data_reg);

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
            aes_inv_sbox u_sbox (
                .addr(shifted[127-8*gi -: 8]),
                .data(subbed[127-8*gi -: 8])
            );
        end
    endgenerate

    assign added = subbed ^ rk;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_mix
            assign mixed[127-32*gi -: 32] = inv_mix_column(added[127-32*gi -: 32]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            round_reg <= 4'd0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            round_reg <= round_next;
            data_reg  <= data_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        round_next = round_reg;
        data_next  = data_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    data_next  = in_data ^ rk;
                    round_next = 4'(NR - 1);
                    state_next = RUN;
                end
            end
            RUN: begin
                // The last round skips InvMixColumns and always terminates.
                if (round_reg == 4'd0) begin
                    data_next  = added;
                    state_next = DONE;
                end else begin
                    data_next  = mixed;
                    round_next = round_reg - 4'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg == RUN) || (state_reg == DONE);
    assign out_data  = data_reg;
    assign rk_idx    = (state_reg == RUN) ? round_reg : 4'(NR);

endmodule

// File: tb/tb_aes_dec_ctrl.sv
// Bench for aes_dec_ctrl: a forward AES-256 model built from field arithmetic
// produces ciphertexts whose plaintexts the DUT must recover.
module tb_aes_dec_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic [3:0]   rk_idx;
    logic [127:0] rk;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_data;
    logic         busy;

    logic [127:0] rk_mem [16];
    logic [7:0]   sbox_f [256];

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    int accept_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rk = rk_mem[rk_idx];

    aes_dec_ctrl dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .rk_idx(rk_idx),
        .rk(rk),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .busy(busy)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    // Forward S-box from the field inverse followed by the affine map.
    function automatic void build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_f[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^
                        rotl8(inv, 4) ^ 8'h63;
        end
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_f[w[31:24]], sbox_f[w[23:16]], sbox_f[w[15:8]], sbox_f[w[7:0]]};
    endfunction

    function automatic void expand_key(input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
                rcon = gf_mul(rcon, 8'h02);
            end else if (i % 8 == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        rk_mem[15] = '0;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   m [4];
        logic [7:0]   acc;
        logic [127:0] res;
        m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
        for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ rk_mem[0][127-8*n -: 8];
        for (int r = 1; r <= 14; r++) begin
            for (int c = 0; c < 4; c++) begin
                for (int row = 0; row < 4; row++) begin
                    t[4*c+row] = sbox_f[s[4*((c+row)%4)+row]];
                end
            end
            for (int c = 0; c < 4; c++) begin
                for (int i = 0; i < 4; i++) begin
                    if (r < 14) begin
                        acc = 8'h00;
                        for (int j = 0; j < 4; j++) acc = acc ^ gf_mul(m[(j-i+4)%4], t[4*c+j]);
                        s[4*c+i] = acc;
                    end else begin
                        s[4*c+i] = t[4*c+i];
                    end
                end
            end
            for (int n = 0; n < 16; n++) s[n] = s[n] ^ rk_mem[r][127-8*n -: 8];
        end
        for (int n = 0; n < 16; n++) res[127-8*n -: 8] = s[n];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", 128'(in_ready), 128'd1);
    endtask

    // Called at a negedge; returns at the negedge where out_valid is seen.
    task automatic run_block(input logic [127:0] ct, input logic [127:0] exp_pt,
                             input bit trace_idx);
        int n;
        wait_ready();
        in_valid = 1'b1;
        in_data  = ct;
        if (trace_idx) check("rk_idx_c0", 128'(rk_idx), 128'd14);
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (trace_idx && n <= 14) check("rk_idx_seq", 128'(rk_idx), 128'(14 - n));
        end while (!out_valid && n < 40);
        check("latency", 128'(n), 128'd15);
        check("out_data", out_data, exp_pt);
        $display("[TB] block ct=%h pt=%h latency=%0d", ct, out_data, n);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] pt;
        logic [127:0] pt2;
        logic [127:0] ct;
        logic [127:0] ct2;
        logic [255:0] key;
        int prev;
        int n;

        build_sbox();
        expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_out_data", out_data, 128'd0);
        check("rst_rk_idx", 128'(rk_idx), 128'd14);

        // Known-answer vector with rk_idx trace
        run_block(128'h8ea2b7ca516745bfeafc49904b496089,
                  128'h00112233445566778899aabbccddeeff, 1'b1);

        // Back-to-back, out_ready held high
        key = {$urandom(), $urandom(), $urandom(), $urandom(),
               $urandom(), $urandom(), $urandom(), $urandom()};
        expand_key(key);
        prev = 0;
        for (int b = 0; b < 4; b++) begin
            pt = rand128();
            ct = encrypt(pt);
            run_block(ct, pt, 1'b0);
            if (b > 0) check("b2b_gap", 128'(accept_cyc - prev), 128'd16);
            prev = accept_cyc;
        end

        // Backpressure with a second block waiting on in_valid
        pt  = rand128();
        ct  = encrypt(pt);
        pt2 = rand128();
        ct2 = encrypt(pt2);
        @(negedge clk);
        out_ready = 1'b0;
        wait_ready();
        in_valid = 1'b1;
        in_data  = ct;
        @(posedge clk);
        #1;
        in_data = ct2;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 40);
        check("bp_latency", 128'(n), 128'd15);
        check("bp_data", out_data, pt);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_hold_data", out_data, pt);
            check("bp_in_ready", 128'(in_ready), 128'd0);
            check("bp_out_valid", 128'(out_valid), 128'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_idle_in_ready", 128'(in_ready), 128'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 40);
        check("bp_second_latency", 128'(n), 128'd15);
        check("bp_second_data", out_data, pt2);
        $display("[TB] backpressure block2 ct=%h pt=%h latency=%0d", ct2, out_data, n);

        // Reset in the middle of a run
        pt = rand128();
        ct = encrypt(pt);
        @(negedge clk);
        wait_ready();
        in_valid = 1'b1;
        in_data  = ct;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_in_ready", 128'(in_ready), 128'd1);
        check("mid_rst_out_valid", 128'(out_valid), 128'd0);
        check("mid_rst_out_data", out_data, 128'd0);
        check("mid_rst_busy", 128'(busy), 128'd0);
        $display("[TB] reset mid-run at cycle 7");
        pt = rand128();
        ct = encrypt(pt);
        run_block(ct, pt, 1'b0);

        // Round-trip over random keys and plaintexts
        for (int i = 0; i < 100; i++) begin
            key = {$urandom(), $urandom(), $urandom(), $urandom(),
                   $urandom(), $urandom(), $urandom(), $urandom()};
            expand_key(key);
            pt = rand128();
            ct = encrypt(pt);
            run_block(ct, pt, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/aes_dec_ctrl.md
# aes_dec_ctrl

Iterative AES-256 inverse-cipher controller: the decryption end of the block-cipher path. It accepts one 128-bit ciphertext block and runs the FIPS-197 inverse cipher, one round per clock, over 14 rounds. Round keys are fetched by index from the external key-schedule store, and the plaintext is returned over a valid/ready output handshake. It sits between the hash/key-derivation front end and the downstream consumer of recovered plaintext.

## Interface
- NR, default 14, number of AES-256 rounds; fixed, not for override.
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  ciphertext block present on in_data.
- in_ready  out  1  block accepted when in_valid && in_ready.
- in_data  in  128  ciphertext; byte 0 = [127:120], column-major state per FIPS-197.
- rk_idx  out  4  round-key index requested, 0..14.
- rk  in  128  round key for rk_idx, combinational (same-cycle) read, same byte order.
- out_valid  out  1  plaintext present on out_data.
- out_ready  in  1  consumer takes block when out_valid && out_ready.
- out_data  out  128  plaintext; driven directly from state register.
- busy  out  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, rk_idx=14.
  - On accept: state <= in_data ^ rk (rk[14]); round <= 13; go to RUN.
- RUN:
  - rk_idx=round.
  - round 13..1: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk); round decrements.
  - round 0: state <= InvSubBytes(InvShiftRows(state)) ^ rk, no InvMixColumns; go to DONE.
- DONE:
  - out_valid=1; out_data holds the state register, stable until handshake.
  - On out_ready: go to IDLE next cycle.
- round: 4-bit down-counter, never wraps below 0. Reaching round 0 in RUN always exits to DONE.
- in_ready=0 outside IDLE. in_valid in RUN/DONE is ignored; the upstream source holds it.
- InvMixColumns: GF(2^8) multiply by 0e/0b/0d/09 mod x^8+x^4+x^3+x+1, built as xtime chains, 8-bit results.
- Inverse S-box: 16 parallel instances of a 256-entry lookup.

## Timing
- Reset values: state=IDLE, in_ready=1 (IDLE), out_valid=0, busy=0, out_data=0, rk_idx=14, round=0.
- Cycle 0: input handshake.
- Cycles 1..14: rounds 13..0.
- Cycle 15: out_valid rises.
- Minimum block period 16 cycles (out_ready held high: DONE 1 cycle, IDLE 1 cycle).
- out_ready low holds DONE indefinitely with out_data unchanged.
- rst mid-RUN or in DONE: next cycle IDLE, out_valid=0, out_data=0, and the partial block is discarded.
- rst wins over a simultaneous in_valid or out_ready.
- rk must be valid in the same cycle rk_idx is driven. rk_idx changes only on clock edges.

## Structure
- Package aes_pkg holds:
  - NR and the state-enum typedef.
  - The inverse S-box table constant.
  - Functions xtime, gmul and inv_mix_column (32-bit), plus inv_shift_rows (128-bit).
- Sub-module aes_inv_sbox: 8-bit in, 8-bit out, combinational lookup from aes_pkg. Instantiated 16 times.
- Key schedule is outside this block.

## Test plan
- FIPS-197 C.3 vector:
  - Stimulus: key 000102…1f expanded by the bench model; ciphertext 8ea2b7ca516745bfeafc49904b496089.
  - Required: out_data=00112233445566778899aabbccddeeff, out_valid at cycle 15.
  - rk_idx sequence 14,13,…,0 in cycles 0..14.
- Backpressure:
  - Stimulus: out_ready low for 10 cycles after out_valid, in_valid held high with a second block.
  - Required: out_data stable, in_ready=0 throughout, second block accepted the cycle after IDLE is re-entered.
- Back-to-back: 4 random blocks with out_ready=1 → each result matches the bench model; acceptances exactly 16 cycles apart.
- Reset mid-run:
  - Stimulus: rst asserted at cycle 7 of a block.
  - Required: next cycle in_ready=1, out_valid=0, out_data=0; a following block decrypts correctly.
- Round-trip: 100 random plaintext/key pairs encrypted by the bench reference, then decrypted → plaintext recovered bit-exact.
